// File: rtl/core_pipeline_ctrl.sv
// Central sequencer for the 3-stage core: owns the PC, arbitrates redirects
// (EX jumps/MRET, interrupt entry, WFI sleep) and drives every stall/flush control.
module core_pipeline_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter bit          WFI_AS_NOP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] next_pc_ex,
  input  logic        jump_en_ex,
  input  logic [31:0] jump_addr_ex,
  input  logic        exception_returned,
  input  logic        wait_for_interrupt,
  input  logic        load_use_hazard,
  input  logic        mem_busy,
  input  logic        irq_pending,
  input  logic        irq_wake,
  input  logic [31:0] trap_vector,
  output logic [31:0] pc,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        trap_enter,
  output logic [31:0] trap_mepc,
  output logic        core_sleeping
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLEEP = 2'd1,
    WAKE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_mepc_q, trap_mepc_d;
  logic        irq_take;

  // An MRET or WFI in EX blocks interrupt entry so the CSR update never collides with them.
  assign irq_take = irq_pending && ex_valid && !exception_returned && !wait_for_interrupt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_ADDR;
      trap_mepc_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      trap_mepc_q <= trap_mepc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    trap_mepc_d   = trap_mepc_q;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    stall_ex      = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    trap_enter    = 1'b0;
    core_sleeping = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
        end else if (irq_take) begin
          trap_enter  = 1'b1;
          trap_mepc_d = jump_en_ex ? jump_addr_ex : next_pc_ex;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          pc_d        = trap_vector;
        end else if (jump_en_ex) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          pc_d        = jump_addr_ex;
        end else if (wait_for_interrupt && !WFI_AS_NOP) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          pc_d        = next_pc_ex;
          state_d     = SLEEP;
        end else if (load_use_hazard) begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          flush_id_ex = 1'b1;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end

      SLEEP: begin
        stall_if      = 1'b1;
        stall_id      = 1'b1;
        flush_id_ex   = 1'b1;
        core_sleeping = 1'b1;
        if (irq_wake) begin
          state_d = WAKE;
        end
      end

      WAKE: begin
        // pc already holds the WFI successor, which is exactly the return address.
        if (mem_busy) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
        end else begin
          state_d = RUN;
          if (irq_pending) begin
            trap_enter  = 1'b1;
            trap_mepc_d = pc_q;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pc_d        = trap_vector;
          end
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Keep every control quiet while reset is held, whatever the inputs do.
    if (!rst_n) begin
      stall_if      = 1'b0;
      stall_id      = 1'b0;
      stall_ex      = 1'b0;
      flush_if_id   = 1'b0;
      flush_id_ex   = 1'b0;
      trap_enter    = 1'b0;
      core_sleeping = 1'b0;
    end
  end

  assign pc        = pc_q;
  assign trap_mepc = trap_enter ? trap_mepc_d : trap_mepc_q;

endmodule

// File: tb/tb_core_pipeline_ctrl.sv
// Self-checking bench for core_pipeline_ctrl: directed scenarios plus randomized
// traffic, all checked against a cycle-level model of the sequencing rules.
module tb_core_pipeline_ctrl;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam bit          WFI_AS_NOP = 1'b0;
  localparam int ModeRunning = 0;
  localparam int ModeAsleep  = 1;
  localparam int ModeWaking  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, jump_en_ex, exception_returned, wait_for_interrupt;
  logic        load_use_hazard, mem_busy, irq_pending, irq_wake;
  logic [31:0] next_pc_ex, jump_addr_ex, trap_vector;
  logic [31:0] pc, trap_mepc;
  logic        stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex;
  logic        trap_enter, core_sleeping;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] modelPc;
  int          modelMode;
  logic        lastTrap;
  logic [31:0] lastMepc;

  core_pipeline_ctrl #(.RESET_ADDR(RESET_ADDR), .WFI_AS_NOP(WFI_AS_NOP)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .next_pc_ex(next_pc_ex),
    .jump_en_ex(jump_en_ex), .jump_addr_ex(jump_addr_ex),
    .exception_returned(exception_returned), .wait_for_interrupt(wait_for_interrupt),
    .load_use_hazard(load_use_hazard), .mem_busy(mem_busy), .irq_pending(irq_pending),
    .irq_wake(irq_wake), .trap_vector(trap_vector), .pc(pc), .stall_if(stall_if),
    .stall_id(stall_id), .stall_ex(stall_ex), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .trap_enter(trap_enter), .trap_mepc(trap_mepc),
    .core_sleeping(core_sleeping)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic idleInputs();
    ex_valid = 1'b1; jump_en_ex = 1'b0; exception_returned = 1'b0;
    wait_for_interrupt = 1'b0; load_use_hazard = 1'b0; mem_busy = 1'b0;
    irq_pending = 1'b0; irq_wake = 1'b0;
  endtask

  // Called at a falling edge with inputs driven: predicts this cycle's outputs,
  // checks them, then advances the model across the rising edge.
  task automatic applyStimulus();
    logic [31:0] nextPc, expMepc;
    int          nextMode;
    logic        sIf, sId, sEx, fIfId, fIdEx, expTrap, expSleep;
    nextPc = modelPc; nextMode = modelMode; expMepc = 32'h0;
    sIf = 0; sId = 0; sEx = 0; fIfId = 0; fIdEx = 0; expTrap = 0; expSleep = 0;
    #1;
    if (modelMode == ModeRunning) begin
      if (mem_busy) begin
        sIf = 1; sId = 1; sEx = 1;
      end else if (irq_pending && ex_valid && !exception_returned && !wait_for_interrupt) begin
        expTrap = 1; expMepc = jump_en_ex ? jump_addr_ex : next_pc_ex;
        fIfId = 1; fIdEx = 1; nextPc = trap_vector;
      end else if (jump_en_ex) begin
        fIfId = 1; fIdEx = 1; nextPc = jump_addr_ex;
      end else if (wait_for_interrupt && !WFI_AS_NOP) begin
        fIfId = 1; fIdEx = 1; nextPc = next_pc_ex; nextMode = ModeAsleep;
      end else if (load_use_hazard) begin
        sIf = 1; sId = 1; fIdEx = 1;
      end else begin
        nextPc = modelPc + 32'd4;
      end
    end else if (modelMode == ModeAsleep) begin
      sIf = 1; sId = 1; fIdEx = 1; expSleep = 1;
      if (irq_wake) nextMode = ModeWaking;
    end else begin
      if (mem_busy) begin
        sIf = 1; sId = 1; sEx = 1;
      end else begin
        nextMode = ModeRunning;
        if (irq_pending) begin
          expTrap = 1; expMepc = modelPc; fIfId = 1; fIdEx = 1; nextPc = trap_vector;
        end
      end
    end
    checkOutput("pc", pc, modelPc);
    checkOutput("stall_if", {31'b0, stall_if}, {31'b0, sIf});
    checkOutput("stall_id", {31'b0, stall_id}, {31'b0, sId});
    checkOutput("stall_ex", {31'b0, stall_ex}, {31'b0, sEx});
    checkOutput("flush_if_id", {31'b0, flush_if_id}, {31'b0, fIfId});
    checkOutput("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, fIdEx});
    checkOutput("trap_enter", {31'b0, trap_enter}, {31'b0, expTrap});
    checkOutput("core_sleeping", {31'b0, core_sleeping}, {31'b0, expSleep});
    if (expTrap) checkOutput("trap_mepc", trap_mepc, expMepc);
    lastTrap = trap_enter;
    lastMepc = trap_mepc;
    @(posedge clk);
    modelPc = nextPc;
    modelMode = nextMode;
    @(negedge clk);
  endtask

  task automatic randomInputs();
    ex_valid           = ($urandom_range(0, 3) != 0);
    next_pc_ex         = $urandom() & 32'hFFFF_FFFC;
    jump_en_ex         = ($urandom_range(0, 4) == 0);
    jump_addr_ex       = $urandom() & 32'hFFFF_FFFC;
    exception_returned = jump_en_ex && ($urandom_range(0, 2) == 0);
    wait_for_interrupt = !jump_en_ex && ($urandom_range(0, 7) == 0);
    load_use_hazard    = ($urandom_range(0, 4) == 0);
    mem_busy           = ($urandom_range(0, 5) == 0);
    irq_pending        = ($urandom_range(0, 4) == 0);
    irq_wake           = irq_pending || ($urandom_range(0, 6) == 0);
    if ($urandom_range(0, 15) == 0) trap_vector = $urandom() & 32'hFFFF_FFFC;
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();
    next_pc_ex = 32'h0; jump_addr_ex = 32'h0; trap_vector = 32'h200;
    modelPc = RESET_ADDR; modelMode = ModeRunning;
    lastTrap = 1'b0; lastMepc = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("resetPc", pc, RESET_ADDR);
    checkOutput("resetCtl", {25'b0, stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex,
                             trap_enter, core_sleeping}, 32'h0);
    checkOutput("resetMepc", trap_mepc, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch after reset, then a taken branch at 0x10.
    repeat (4) applyStimulus();
    checkOutput("seqPc", pc, 32'h10);
    jump_en_ex = 1'b1; jump_addr_ex = 32'h100;
    applyStimulus();
    jump_en_ex = 1'b0;
    checkOutput("branchPc", pc, 32'h100);
    checkOutput("branchNoTrap", {31'b0, lastTrap}, 32'h0);

    // Load-use bubble at 0x20, then a three-cycle bus freeze.
    jump_en_ex = 1'b1; jump_addr_ex = 32'h20;
    applyStimulus();
    jump_en_ex = 1'b0; load_use_hazard = 1'b1;
    applyStimulus();
    load_use_hazard = 1'b0;
    checkOutput("loadUseHold", pc, 32'h20);
    applyStimulus();
    checkOutput("loadUseResume", pc, 32'h24);
    mem_busy = 1'b1;
    repeat (3) applyStimulus();
    mem_busy = 1'b0;
    checkOutput("busyHold", pc, 32'h24);

    // WFI, woken by an enabled interrupt.
    wait_for_interrupt = 1'b1; next_pc_ex = 32'h44;
    applyStimulus();
    wait_for_interrupt = 1'b0;
    checkOutput("sleeping", {31'b0, core_sleeping}, 32'h1);
    irq_wake = 1'b1; irq_pending = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("wakeTrap", {31'b0, lastTrap}, 32'h1);
    checkOutput("wakeMepc", lastMepc, 32'h44);
    checkOutput("wakeVector", pc, 32'h200);

    // WFI, woken by a masked interrupt.
    irq_wake = 1'b0; irq_pending = 1'b0; wait_for_interrupt = 1'b1;
    applyStimulus();
    wait_for_interrupt = 1'b0; irq_wake = 1'b1;
    applyStimulus();
    applyStimulus();
    irq_wake = 1'b0;
    checkOutput("maskedNoTrap", {31'b0, lastTrap}, 32'h0);
    checkOutput("maskedResume", pc, 32'h44);

    // Interrupt coinciding with a jump, then with an MRET.
    irq_pending = 1'b1; jump_en_ex = 1'b1; jump_addr_ex = 32'h80;
    applyStimulus();
    checkOutput("jumpIrqMepc", lastMepc, 32'h80);
    checkOutput("jumpIrqPc", pc, 32'h200);
    exception_returned = 1'b1;
    applyStimulus();
    checkOutput("mretNoTrap", {31'b0, lastTrap}, 32'h0);
    checkOutput("mretPc", pc, 32'h80);
    exception_returned = 1'b0; jump_en_ex = 1'b0; next_pc_ex = 32'h80;
    applyStimulus();
    irq_pending = 1'b0;
    checkOutput("postMretTrap", {31'b0, lastTrap}, 32'h1);
    checkOutput("postMretMepc", lastMepc, 32'h80);

    // PC wraps at the top of the address space.
    jump_en_ex = 1'b1; jump_addr_ex = 32'hFFFF_FFFC;
    applyStimulus();
    jump_en_ex = 1'b0;
    applyStimulus();
    checkOutput("pcWrap", pc, 32'h0);

    // Asynchronous reset while asleep.
    wait_for_interrupt = 1'b1; next_pc_ex = 32'h300;
    applyStimulus();
    wait_for_interrupt = 1'b0;
    applyStimulus();
    irq_pending = 1'b1; irq_wake = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstPc", pc, RESET_ADDR);
    checkOutput("asyncRstSleep", {31'b0, core_sleeping}, 32'h0);
    checkOutput("asyncRstTrap", {31'b0, trap_enter}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      #1 checkOutput("rstHeldTrap", {31'b0, trap_enter}, 32'h0);
    end
    @(negedge clk);
    idleInputs();
    rst_n = 1'b1;
    modelPc = RESET_ADDR; modelMode = ModeRunning;
    applyStimulus();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      randomInputs();
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
